// File: rtl/sim_exit_pkg.sv
// Shared types and helpers for the simulation exit controller.
package sim_exit_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} sim_exit_state_e;

  localparam logic [31:0] DefaultTimeoutCode = 32'hDEAD;

  // Widest exit word decode_exit can split; ValueWidth must not exceed it.
  localparam int unsigned MaxValueWidth = 64;

  typedef struct packed {
    logic                     flag;
    logic [MaxValueWidth-2:0] code;
  } exit_word_t;

  function automatic exit_word_t decode_exit(input logic [MaxValueWidth-1:0] word);
    exit_word_t dec;
    dec.flag = word[0];
    dec.code = word[MaxValueWidth-1:1];
    return dec;
  endfunction

endpackage

// File: rtl/sim_exit_watchdog.sv
// Saturating no-progress counter; expire_o flags the cycle that reaches Limit-1.
module sim_exit_watchdog #(
  parameter int unsigned Width = 4,
  parameter int unsigned Limit = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [Width-1:0] LastCnt = Width'(Limit - 1);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign expire_o = en_i && (cnt_q >= LastCnt);

endmodule

// File: rtl/sim_exit_ctrl.sv
// Aggregates per-channel exit words into one sticky exit status, with optional watchdog.
// Define SIM_EXIT_CTRL_TRACE_EN for simulation-only exit tracing and X checks.
module sim_exit_ctrl
  import sim_exit_pkg::*;
#(
  parameter int unsigned NumChan       = 4,
  parameter int unsigned ValueWidth    = 32,
  parameter bit          WaitAll       = 1'b0,
  parameter int unsigned TimeoutCycles = 32'd0,
  parameter logic [31:0] TimeoutCode   = DefaultTimeoutCode,
  localparam int unsigned ChanW        = (NumChan > 1) ? $clog2(NumChan) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic [NumChan-1:0]            chan_wr_valid_i,
  input  logic [NumChan*ValueWidth-1:0] chan_wr_data_i,
  output logic                          exit_valid_o,
  output logic [ValueWidth-1:0]         exit_value_o,
  output logic [ChanW-1:0]              exit_chan_o,
  output logic                          timeout_o,
  output logic [NumChan-1:0]            done_mask_o
);

  localparam int unsigned CodeW = ValueWidth - 1;
  localparam int unsigned CntW  =
      (TimeoutCycles == 0) ? 1 : $clog2(64'(TimeoutCycles) + 64'd1);

  sim_exit_state_e       state_q;
  logic [NumChan-1:0]    done_mask_q, done_mask_d, new_exit;
  logic [CodeW-1:0]      code_q [NumChan];
  logic [CodeW-1:0]      code_d [NumChan];
  exit_word_t            dec    [NumChan];
  logic                  exit_valid_q, timeout_q;
  logic [ValueWidth-1:0] exit_value_q;
  logic [ChanW-1:0]      exit_chan_q;

  logic                  run_act, wd_expire;
  logic                  fin_d, tmo_d;
  logic [ValueWidth-1:0] value_d;
  logic [ChanW-1:0]      chan_d;

  assign run_act = (state_q == StRun) && enable_i;

  always_comb begin
    for (int c = 0; c < NumChan; c++) begin
      dec[c]      = decode_exit(MaxValueWidth'(chan_wr_data_i[c*ValueWidth +: ValueWidth]));
      new_exit[c] = run_act && chan_wr_valid_i[c] && dec[c].flag && !done_mask_q[c];
      code_d[c]   = new_exit[c] ? CodeW'(dec[c].code) : code_q[c];
    end
    done_mask_d = done_mask_q | new_exit;
  end

  // Descending scans so the lowest qualifying channel is the last to assign.
  always_comb begin
    fin_d   = 1'b0;
    tmo_d   = 1'b0;
    value_d = '0;
    chan_d  = '0;
    if (WaitAll) begin
      if ((|new_exit) && (&done_mask_d)) begin
        fin_d = 1'b1;
        for (int c = NumChan - 1; c >= 0; c--) begin
          if (code_d[c] != '0) begin
            value_d = ValueWidth'(code_d[c]);
            chan_d  = ChanW'(c);
          end
        end
      end
    end else if (|new_exit) begin
      fin_d = 1'b1;
      for (int c = NumChan - 1; c >= 0; c--) begin
        if (new_exit[c]) begin
          value_d = ValueWidth'(code_d[c]);
          chan_d  = ChanW'(c);
        end
      end
    end
    if (!fin_d && wd_expire) begin
      fin_d   = 1'b1;
      tmo_d   = 1'b1;
      value_d = ValueWidth'(TimeoutCode);
      chan_d  = '0;
    end
  end

  if (TimeoutCycles != 0) begin : g_wdog
    logic wr_any;
    assign wr_any = run_act && (|chan_wr_valid_i);
    sim_exit_watchdog #(
      .Width (CntW),
      .Limit (TimeoutCycles)
    ) u_wdog (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (wr_any),
      .en_i     (run_act && !wr_any),
      .expire_o (wd_expire)
    );
  end else begin : g_no_wdog
    assign wd_expire = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      done_mask_q  <= '0;
      exit_valid_q <= 1'b0;
      exit_value_q <= ValueWidth'(1);
      exit_chan_q  <= '0;
      timeout_q    <= 1'b0;
      for (int c = 0; c < NumChan; c++) code_q[c] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable_i) state_q <= StRun;
        end
        StRun: begin
          if (!enable_i) begin
            state_q <= StIdle;
          end else begin
            done_mask_q <= done_mask_d;
            code_q      <= code_d;
            if (fin_d) begin
              state_q      <= StDone;
              exit_valid_q <= 1'b1;
              exit_value_q <= value_d;
              exit_chan_q  <= chan_d;
              timeout_q    <= tmo_d;
            end
          end
        end
        StDone: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign exit_valid_o = exit_valid_q;
  assign exit_value_o = exit_value_q;
  assign exit_chan_o  = exit_chan_q;
  assign timeout_o    = timeout_q;
  assign done_mask_o  = done_mask_q;

`ifdef SIM_EXIT_CTRL_TRACE_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!$isunknown(chan_wr_valid_i))
        else $error("sim_exit_ctrl: X on chan_wr_valid_i");
      for (int c = 0; c < NumChan; c++) begin
        if (new_exit[c]) begin
          $display("%0t sim_exit_ctrl: chan %0d exit code %0h", $time, c, code_d[c]);
        end
      end
      if (run_act && fin_d) begin
        $display("%0t sim_exit_ctrl: done value %0h chan %0d timeout %0b",
                 $time, value_d, chan_d, tmo_d);
      end
    end
  end
`else
  // Trace disabled: no simulation-only code is built.
`endif

endmodule
